// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   DATA_W / ADDR_W : default register data width and register index width
//   CH_ALU / CH_LD  : channel indices (ALU result, load data)
//   wb_entry_t      : one queued register write {rd, data} at default widths
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam logic CH_ALU = 1'b0;
    localparam logic CH_LD  = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry writeback queue. Slot 0 is always the head, so a pop is a shift.
// The valid bit and rd of every slot are exported so the top level can build
// its pending-write scoreboard.
//   push_i/push_rd_i/push_data_i : enqueue request (ignored when full)
//   pop_i                        : dequeue head (ignored when empty)
//   full_o/empty_o               : occupancy flags
//   head_rd_o/head_data_o        : head entry
//   ent_vld_o/ent_rd_o           : per-slot valid and destination register
module wb_fifo2 #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [ADDR_W-1:0]      push_rd_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [ADDR_W-1:0]      head_rd_o,
    output logic [DATA_W-1:0]      head_data_o,
    output logic [1:0]             ent_vld_o,
    output logic [1:0][ADDR_W-1:0] ent_rd_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_after_pop_s;
    logic [1:0][ADDR_W-1:0] rd_q, rd_d;
    logic [1:0][DATA_W-1:0] data_q, data_d;
    logic                   push_s, pop_s;

    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign empty_o     = (cnt_q == {CNT_W{1'b0}});
    assign push_s      = push_i && !full_o;
    assign pop_s       = pop_i && !empty_o;
    assign head_rd_o   = rd_q[0];
    assign head_data_o = data_q[0];
    assign ent_vld_o   = {(cnt_q == CNT_W'(2'd2)), !empty_o};
    assign ent_rd_o    = rd_q;

    // Next-state: shift on pop, then write the push into the first free slot.
    always_comb begin
        rd_d            = rd_q;
        data_d          = data_q;
        cnt_after_pop_s = cnt_q - CNT_W'(pop_s);
        if (pop_s) begin
            rd_d[0]   = rd_q[1];
            data_d[0] = data_q[1];
        end else begin
            rd_d[0]   = rd_q[0];
            data_d[0] = data_q[0];
        end
        if (push_s) begin
            // Push with a simultaneous pop of a single entry lands in slot 0.
            if (cnt_after_pop_s == {CNT_W{1'b0}}) begin
                rd_d[0]   = push_rd_i;
                data_d[0] = push_data_i;
            end else begin
                rd_d[1]   = push_rd_i;
                data_d[1] = push_data_i;
            end
        end else begin
            rd_d[1]   = rd_q[1];
            data_d[1] = data_q[1];
        end
        cnt_d = cnt_after_pop_s + CNT_W'(push_s);
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CNT_W{1'b0}};
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the register file write port between the ALU (channel 0) and load
// (channel 1) writeback paths. Each channel feeds a 2-entry queue; heads are
// served round-robin into a registered write stage. A scoreboard marks every
// register with a write still queued or staged.
//   chN_valid/chN_ready/chN_rd/chN_data : writeback request handshakes
//   reg_write_en/rd/rd_value            : registered register-file write port
//   q_rs1/q_rs2 -> rs1_busy/rs2_busy    : hazard queries
//   busy_vec                            : per-register pending-write bits
module wb_write_arbiter #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ch0_valid,
    output logic                   ch0_ready,
    input  logic [ADDR_W-1:0]      ch0_rd,
    input  logic [DATA_W-1:0]      ch0_data,
    input  logic                   ch1_valid,
    output logic                   ch1_ready,
    input  logic [ADDR_W-1:0]      ch1_rd,
    input  logic [DATA_W-1:0]      ch1_data,
    output logic                   reg_write_en,
    output logic [ADDR_W-1:0]      rd,
    output logic [DATA_W-1:0]      rd_value,
    input  logic [ADDR_W-1:0]      q_rs1,
    input  logic [ADDR_W-1:0]      q_rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [(2**ADDR_W)-1:0] busy_vec
);

    import wb_pkg::*;

    localparam int NREG = 2**ADDR_W;

    function automatic logic [NREG-1:0] onehot_f(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] v;
        v      = {NREG{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    logic                   f0_full_s, f0_empty_s, f1_full_s, f1_empty_s;
    logic [ADDR_W-1:0]      f0_head_rd_s, f1_head_rd_s;
    logic [DATA_W-1:0]      f0_head_data_s, f1_head_data_s;
    logic [1:0]             f0_vld_s, f1_vld_s;
    logic [1:0][ADDR_W-1:0] f0_rd_s, f1_rd_s;
    logic                   push0_s, push1_s, pop0_s, pop1_s;
    logic                   gnt_vld_s, gnt_ch_s;
    logic [ADDR_W-1:0]      gnt_rd_s;
    logic [DATA_W-1:0]      gnt_data_s;
    logic                   last_grant_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      wr_rd_q;
    logic [DATA_W-1:0]      wr_data_q;
    logic [NREG-1:0]        busy_s;

    // Ready depends on queue state only; writes to x0 are swallowed at the door.
    assign ch0_ready = !f0_full_s;
    assign ch1_ready = !f1_full_s;
    assign push0_s   = ch0_valid && !f0_full_s && (ch0_rd != {ADDR_W{1'b0}});
    assign push1_s   = ch1_valid && !f1_full_s && (ch1_rd != {ADDR_W{1'b0}});

    wb_fifo2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_alu (
        .clk(clk), .rst_n(rst_n),
        .push_i(push0_s), .push_rd_i(ch0_rd), .push_data_i(ch0_data), .pop_i(pop0_s),
        .full_o(f0_full_s), .empty_o(f0_empty_s),
        .head_rd_o(f0_head_rd_s), .head_data_o(f0_head_data_s),
        .ent_vld_o(f0_vld_s), .ent_rd_o(f0_rd_s)
    );

    wb_fifo2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_ld (
        .clk(clk), .rst_n(rst_n),
        .push_i(push1_s), .push_rd_i(ch1_rd), .push_data_i(ch1_data), .pop_i(pop1_s),
        .full_o(f1_full_s), .empty_o(f1_empty_s),
        .head_rd_o(f1_head_rd_s), .head_data_o(f1_head_data_s),
        .ent_vld_o(f1_vld_s), .ent_rd_o(f1_rd_s)
    );

    // Round-robin grant over the two queue heads.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_ch_s  = CH_ALU;
        case ({!f1_empty_s, !f0_empty_s})
            2'b01: begin
                gnt_vld_s = 1'b1;
                gnt_ch_s  = CH_ALU;
            end
            2'b10: begin
                gnt_vld_s = 1'b1;
                gnt_ch_s  = CH_LD;
            end
            2'b11: begin
                gnt_vld_s = 1'b1;
                gnt_ch_s  = (last_grant_q == CH_ALU) ? CH_LD : CH_ALU;
            end
            default: begin
                gnt_vld_s = 1'b0;
                gnt_ch_s  = CH_ALU;
            end
        endcase
    end

    assign pop0_s     = gnt_vld_s && (gnt_ch_s == CH_ALU);
    assign pop1_s     = gnt_vld_s && (gnt_ch_s == CH_LD);
    assign gnt_rd_s   = (gnt_ch_s == CH_LD) ? f1_head_rd_s : f0_head_rd_s;
    assign gnt_data_s = (gnt_ch_s == CH_LD) ? f1_head_data_s : f0_head_data_s;

    // Registered write stage; rd/rd_value hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            wr_rd_q      <= {ADDR_W{1'b0}};
            wr_data_q    <= {DATA_W{1'b0}};
            last_grant_q <= CH_LD;
        end else begin
            we_q <= gnt_vld_s;
            if (gnt_vld_s) begin
                wr_rd_q      <= gnt_rd_s;
                wr_data_q    <= gnt_data_s;
                last_grant_q <= gnt_ch_s;
            end
        end
    end

    assign reg_write_en = we_q;
    assign rd           = wr_rd_q;
    assign rd_value     = wr_data_q;

    // Pending-write scoreboard: every queued entry plus the staged write.
    always_comb begin
        busy_s = {NREG{1'b0}};
        for (int i = 0; i < 2; i++) begin
            busy_s = busy_s | ({NREG{f0_vld_s[i]}} & onehot_f(f0_rd_s[i]))
                            | ({NREG{f1_vld_s[i]}} & onehot_f(f1_rd_s[i]));
        end
        busy_s    = busy_s | ({NREG{we_q}} & onehot_f(wr_rd_q));
        busy_s[0] = 1'b0;
    end

    assign busy_vec = busy_s;
    assign rs1_busy = busy_s[q_rs1];
    assign rs2_busy = busy_s[q_rs2];

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic        ch0_ready, ch1_ready;
    logic [2:0]  ch0_rd = 3'd0, ch1_rd = 3'd0;
    logic [31:0] ch0_data = 32'd0, ch1_data = 32'd0;
    logic        reg_write_en;
    logic [2:0]  rd;
    logic [31:0] rd_value;
    logic [2:0]  q_rs1 = 3'd0, q_rs2 = 3'd0;
    logic        rs1_busy, rs2_busy;
    logic [7:0]  busy_vec;

    wb_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_valid(ch0_valid), .ch0_ready(ch0_ready), .ch0_rd(ch0_rd), .ch0_data(ch0_data),
        .ch1_valid(ch1_valid), .ch1_ready(ch1_ready), .ch1_rd(ch1_rd), .ch1_data(ch1_data),
        .reg_write_en(reg_write_en), .rd(rd), .rd_value(rd_value),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [2:0]  rd;
        logic [31:0] data;
        logic [2:0]  q1;
        logic [2:0]  q2;
        logic [7:0]  busy;
        logic        rs1;
        logic        rs2;
        logic        we;
    } vec_t;

    vec_t      vecs [6];
    wb_entry_t exp_q [$];
    wb_entry_t src0 [$];
    wb_entry_t src1 [$];
    logic      ready0_tr [0:63];
    int        n_cmp = 0;
    int        n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic wb_entry_t mk(input logic ch, input logic [2:0] r);
        wb_entry_t e;
        e.rd   = r;
        e.data = (ch ? 32'hB000_0000 : 32'hA000_0000) | {29'd0, r};
        return e;
    endfunction

    task automatic drive(input logic ch, input logic v, input logic [2:0] r, input logic [31:0] d);
        if (ch == CH_LD) begin
            ch1_valid = v; ch1_rd = r; ch1_data = d;
        end else begin
            ch0_valid = v; ch0_rd = r; ch0_data = d;
        end
    endtask

    // Write-port scoreboard: every write must match the next expected entry.
    task automatic monitor();
        wb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && reg_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_rd", {61'd0, rd}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_rd", {61'd0, rd}, {61'd0, e.rd});
                    check("write_value", {32'd0, rd_value}, {32'd0, e.data});
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        exp_q.delete();
        src0.delete();
        src1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives src0/src1 with valid held until accepted; records ch0_ready per cycle.
    task automatic run_stream(input string name);
        int  cyc;
        logic a0, a1;
        cyc = 0;
        while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0) && cyc < 40) begin
            @(negedge clk);
            ch0_valid = (src0.size() > 0);
            if (src0.size() > 0) begin ch0_rd = src0[0].rd; ch0_data = src0[0].data; end
            ch1_valid = (src1.size() > 0);
            if (src1.size() > 0) begin ch1_rd = src1[0].rd; ch1_data = src1[0].data; end
            ready0_tr[cyc] = ch0_ready;
            a0 = ch0_valid && ch0_ready;
            a1 = ch1_valid && ch1_ready;
            @(posedge clk);
            if (a0) void'(src0.pop_front());
            if (a1) void'(src1.pop_front());
            cyc++;
        end
        @(negedge clk);
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        check({name, "_drained"}, {63'd0, (cyc < 40)}, 64'd1);
        check({name, "_exp_left"}, exp_q.size(), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] ord_rd [7];
        logic       ord_ch [7];

        vecs[0] = '{1'b0, 3'd3, 32'h0000_1234, 3'd3, 3'd2, 8'h08, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 3'd5, 32'hCAFE_0005, 3'd5, 3'd2, 8'h20, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 3'd0, 32'h0000_DEAD, 3'd0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 3'd7, 32'hFFFF_FFFF, 3'd6, 3'd7, 8'h80, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 3'd0, 32'h0000_5555, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 3'd1, 32'h0000_0001, 3'd1, 3'd0, 8'h02, 1'b1, 1'b0, 1'b1};

        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", {63'd0, reg_write_en}, 64'd0);
        check("rst_rd", {61'd0, rd}, 64'd0);
        check("rst_value", {32'd0, rd_value}, 64'd0);
        check("rst_busy", {56'd0, busy_vec}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready0", {63'd0, ch0_ready}, 64'd1);
        check("rst_ready1", {63'd0, ch1_ready}, 64'd1);

        // Table of single writes: latency, busy window, queries, x0 discard
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            q_rs1 = vecs[i].q1;
            q_rs2 = vecs[i].q2;
            drive(vecs[i].ch, 1'b1, vecs[i].rd, vecs[i].data);
            check($sformatf("v%0d_ready_pre", i), {63'd0, (vecs[i].ch ? ch1_ready : ch0_ready)}, 64'd1);
            if (vecs[i].we) exp_q.push_back('{rd: vecs[i].rd, data: vecs[i].data});
            @(posedge clk);
            #1;
            drive(vecs[i].ch, 1'b0, vecs[i].rd, vecs[i].data);
            check($sformatf("v%0d_busy_e0", i), {56'd0, busy_vec}, {56'd0, vecs[i].busy});
            check($sformatf("v%0d_rs1", i), {63'd0, rs1_busy}, {63'd0, vecs[i].rs1});
            check($sformatf("v%0d_rs2", i), {63'd0, rs2_busy}, {63'd0, vecs[i].rs2});
            check($sformatf("v%0d_we_e0", i), {63'd0, reg_write_en}, 64'd0);
            check($sformatf("v%0d_ready_post", i), {63'd0, (vecs[i].ch ? ch1_ready : ch0_ready)}, 64'd1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we_e1", i), {63'd0, reg_write_en}, {63'd0, vecs[i].we});
            check($sformatf("v%0d_busy_e1", i), {56'd0, busy_vec}, {56'd0, vecs[i].busy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we_e2", i), {63'd0, reg_write_en}, 64'd0);
            check($sformatf("v%0d_busy_e2", i), {56'd0, busy_vec}, 64'd0);
        end

        // Tie round-robin: ch0 rd 1..4 against ch1 rd 5..7, channel 0 first
        do_reset();
        for (int r = 1; r <= 4; r++) src0.push_back(mk(CH_ALU, 3'(r)));
        for (int r = 5; r <= 7; r++) src1.push_back(mk(CH_LD, 3'(r)));
        ord_rd = '{3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7, 3'd4};
        ord_ch = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) exp_q.push_back(mk(ord_ch[k], ord_rd[k]));
        run_stream("tie");

        // Backpressure: ch0 offers three entries while ch1 stays occupied
        do_reset();
        src0.push_back(mk(CH_ALU, 3'd1));
        src0.push_back(mk(CH_ALU, 3'd2));
        src0.push_back(mk(CH_ALU, 3'd3));
        src1.push_back(mk(CH_LD, 3'd6));
        src1.push_back(mk(CH_LD, 3'd7));
        exp_q.push_back(mk(CH_ALU, 3'd1));
        exp_q.push_back(mk(CH_LD, 3'd6));
        exp_q.push_back(mk(CH_ALU, 3'd2));
        exp_q.push_back(mk(CH_LD, 3'd7));
        exp_q.push_back(mk(CH_ALU, 3'd3));
        run_stream("bp");
        check("bp_ready0_c0", {63'd0, ready0_tr[0]}, 64'd1);
        check("bp_ready0_c1", {63'd0, ready0_tr[1]}, 64'd1);
        check("bp_ready0_c2", {63'd0, ready0_tr[2]}, 64'd1);
        check("bp_ready0_full", {63'd0, ready0_tr[3]}, 64'd0);

        // Reset in the middle of a burst with both queues occupied
        do_reset();
        @(negedge clk);
        drive(CH_ALU, 1'b1, 3'd2, 32'h0000_0022);
        drive(CH_LD, 1'b1, 3'd3, 32'h0000_0033);
        exp_q.push_back('{rd: 3'd2, data: 32'h0000_0022});
        @(negedge clk);
        drive(CH_ALU, 1'b1, 3'd4, 32'h0000_0044);
        drive(CH_LD, 1'b1, 3'd5, 32'h0000_0055);
        @(negedge clk);
        drive(CH_ALU, 1'b0, 3'd0, 32'h0);
        drive(CH_LD, 1'b0, 3'd0, 32'h0);
        check("mid_busy_before_rst", {56'd0, busy_vec}, 64'h3C);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {63'd0, reg_write_en}, 64'd0);
        check("mid_rst_rd", {61'd0, rd}, 64'd0);
        check("mid_rst_value", {32'd0, rd_value}, 64'd0);
        check("mid_rst_busy", {56'd0, busy_vec}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_ready0", {63'd0, ch0_ready}, 64'd1);
        check("mid_ready1", {63'd0, ch1_ready}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_idle_we%0d", c), {63'd0, reg_write_en}, 64'd0);
            check($sformatf("mid_idle_busy%0d", c), {56'd0, busy_vec}, 64'd0);
        end

        @(negedge clk);
        check("final_exp_left", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
